// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter: FSM states, requester IDs and
// the bundled memory command.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        ACK
    } arb_state_e;

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic       REQ_CPU = 1'b0;
    localparam logic       REQ_EXT = 1'b1;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  rdop;
        logic [1:0]  wrop;
        logic        rdsign;
    } mem_cmd_t;

    // A combined read+write command is issued as a pure write.
    function automatic mem_cmd_t sanitize_cmd(input mem_cmd_t c);
        mem_cmd_t r;
        r = c;
        if (c.wrop != OP_NONE) begin
            r.rdop = OP_NONE;
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arb_starve.sv
// Grant selection with CPU priority, bounded by a starvation counter that
// forces an external-master grant after STARVE_MAX consecutive CPU grants.
module dmem_arb_starve #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic cpu_req,
    input  logic ext_req,
    input  logic grant,
    input  logic gnt_id,
    output logic sel_ext
);
    import dmem_arb_pkg::*;

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q;
    logic [3:0] starve_cnt_d;

    always_comb begin
        sel_ext      = ext_req && (!cpu_req || (starve_cnt_q == CNT_MAX));
        starve_cnt_d = starve_cnt_q;
        if (!ext_req) begin
            starve_cnt_d = '0;
        end else if (grant) begin
            if (gnt_id == REQ_EXT) begin
                starve_cnt_d = '0;
            end else if (starve_cnt_q != CNT_MAX) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage / external master) in front of the
// single data-memory port; registered one-cycle command, ack with read data.
module dmem_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [1:0]  cpu_rdop,
    input  logic [1:0]  cpu_wrop,
    input  logic        cpu_rdsign,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        ext_req,
    input  logic [31:0] ext_addr,
    input  logic [31:0] ext_wdata,
    input  logic [1:0]  ext_rdop,
    input  logic [1:0]  ext_wrop,
    input  logic        ext_rdsign,
    output logic        ext_ack,
    output logic [31:0] ext_rdata,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [1:0]  m_rdop,
    output logic [1:0]  m_wrop,
    output logic        m_rdsign,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        gnt_id
);
    import dmem_arb_pkg::*;

    localparam logic [1:0] WAIT_INIT = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

    arb_state_e  state_q, state_d;
    logic        gnt_id_q, gnt_id_d;
    mem_cmd_t    cmd_q, cmd_d;
    logic [1:0]  wait_cnt_q, wait_cnt_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] ext_rdata_q, ext_rdata_d;

    mem_cmd_t    cpu_cmd, ext_cmd;
    logic        grant, sel_ext, capture;
    logic [31:0] cap_data;

    assign cpu_cmd = '{addr: cpu_addr, wdata: cpu_wdata, rdop: cpu_rdop,
                       wrop: cpu_wrop, rdsign: cpu_rdsign};
    assign ext_cmd = '{addr: ext_addr, wdata: ext_wdata, rdop: ext_rdop,
                       wrop: ext_wrop, rdsign: ext_rdsign};

    dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
        .clk     (clk),
        .reset   (reset),
        .cpu_req (cpu_req),
        .ext_req (ext_req),
        .grant   (grant),
        .gnt_id  (gnt_id_d),
        .sel_ext (sel_ext)
    );

    always_comb begin
        state_d     = state_q;
        gnt_id_d    = gnt_id_q;
        cmd_d       = cmd_q;
        cmd_d.rdop  = OP_NONE;   // strobes live only in CMD; addr/wdata/rdsign hold
        cmd_d.wrop  = OP_NONE;
        wait_cnt_d  = wait_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ext_rdata_d = ext_rdata_q;
        grant       = 1'b0;
        capture     = 1'b0;
        cap_data    = '0;
        case (state_q)
            IDLE: begin
                if (cpu_req || ext_req) begin
                    grant    = 1'b1;
                    gnt_id_d = sel_ext ? REQ_EXT : REQ_CPU;
                    cmd_d    = sanitize_cmd(sel_ext ? ext_cmd : cpu_cmd);
                    state_d  = CMD;
                end
            end
            CMD: begin
                if (cmd_q.rdop == OP_NONE) begin
                    capture = 1'b1;
                    state_d = ACK;
                end else if (RD_LAT == 0) begin
                    capture  = 1'b1;
                    cap_data = m_rdata;
                    state_d  = ACK;
                end else begin
                    wait_cnt_d = WAIT_INIT;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt_q == '0) begin
                    capture  = 1'b1;
                    cap_data = m_rdata;
                    state_d  = ACK;
                end else begin
                    wait_cnt_d = wait_cnt_q - 2'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (capture) begin
            if (gnt_id_q == REQ_EXT) begin
                ext_rdata_d = cap_data;
            end else begin
                cpu_rdata_d = cap_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_id_q    <= REQ_CPU;
            cmd_q       <= '0;
            wait_cnt_q  <= '0;
            cpu_rdata_q <= '0;
            ext_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_id_q    <= gnt_id_d;
            cmd_q       <= cmd_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ext_rdata_q <= ext_rdata_d;
        end
    end

    assign cpu_ack   = (state_q == ACK) && (gnt_id_q == REQ_CPU);
    assign ext_ack   = (state_q == ACK) && (gnt_id_q == REQ_EXT);
    assign cpu_rdata = cpu_rdata_q;
    assign ext_rdata = ext_rdata_q;
    assign m_addr    = cmd_q.addr;
    assign m_wdata   = cmd_q.wdata;
    assign m_rdop    = cmd_q.rdop;
    assign m_wrop    = cmd_q.wrop;
    assign m_rdsign  = cmd_q.rdsign;
    assign busy      = (state_q != IDLE);
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: RD_LAT=1 instance on a byte memory model,
// plus an RD_LAT=0 instance on a combinational address-derived data source.
module tb_dmem_arbiter;

    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned STARVE_MAX = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic        cpu_req = 1'b0, ext_req = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0, ext_addr = '0, ext_wdata = '0;
    logic [1:0]  cpu_rdop = '0, cpu_wrop = '0, ext_rdop = '0, ext_wrop = '0;
    logic        cpu_rdsign = 1'b0, ext_rdsign = 1'b0;
    logic        cpu_ack, ext_ack, m_rdsign, busy, gnt_id;
    logic [31:0] cpu_rdata, ext_rdata, m_addr, m_wdata, m_rdata;
    logic [1:0]  m_rdop, m_wrop;

    dmem_arbiter #(.RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdop(cpu_rdop), .cpu_wrop(cpu_wrop), .cpu_rdsign(cpu_rdsign),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .ext_req(ext_req), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
        .ext_rdop(ext_rdop), .ext_wrop(ext_wrop), .ext_rdsign(ext_rdsign),
        .ext_ack(ext_ack), .ext_rdata(ext_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_rdop(m_rdop), .m_wrop(m_wrop),
        .m_rdsign(m_rdsign), .m_rdata(m_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    // RD_LAT=0 instance: memory returns addr ^ 0x5A5A0000 combinationally
    logic        z_cpu_req = 1'b0;
    logic [31:0] z_cpu_addr = '0;
    logic [1:0]  z_cpu_rdop = '0, z_cpu_wrop = '0;
    logic        z_cpu_ack, z_ext_ack, z_m_rdsign, z_busy, z_gnt_id;
    logic [31:0] z_cpu_rdata, z_ext_rdata, z_m_addr, z_m_wdata, z_m_rdata;
    logic [1:0]  z_m_rdop, z_m_wrop;
    assign z_m_rdata = z_m_addr ^ 32'h5A5A_0000;

    dmem_arbiter #(.RD_LAT(0), .STARVE_MAX(STARVE_MAX)) dut0 (
        .clk(clk), .reset(reset),
        .cpu_req(z_cpu_req), .cpu_addr(z_cpu_addr), .cpu_wdata(32'h0),
        .cpu_rdop(z_cpu_rdop), .cpu_wrop(z_cpu_wrop), .cpu_rdsign(1'b0),
        .cpu_ack(z_cpu_ack), .cpu_rdata(z_cpu_rdata),
        .ext_req(1'b0), .ext_addr(32'h0), .ext_wdata(32'h0),
        .ext_rdop(2'b00), .ext_wrop(2'b00), .ext_rdsign(1'b0),
        .ext_ack(z_ext_ack), .ext_rdata(z_ext_rdata),
        .m_addr(z_m_addr), .m_wdata(z_m_wdata), .m_rdop(z_m_rdop), .m_wrop(z_m_wrop),
        .m_rdsign(z_m_rdsign), .m_rdata(z_m_rdata), .busy(z_busy), .gnt_id(z_gnt_id)
    );

    // Byte memory, little-endian; op 01=byte, 10=half, 11=word; one-cycle read latency
    logic [7:0]  mem [0:255];
    logic [31:0] rd_pipe = '0;

    function automatic logic [31:0] mem_read(input logic [7:0] a, input logic [1:0] op,
                                             input logic sgn);
        logic [7:0]  b0, b1, b2, b3;
        b0 = mem[a]; b1 = mem[a + 8'd1]; b2 = mem[a + 8'd2]; b3 = mem[a + 8'd3];
        case (op)
            2'b01:   return sgn ? {{24{b0[7]}}, b0} : {24'h0, b0};
            2'b10:   return sgn ? {{16{b1[7]}}, b1, b0} : {16'h0, b1, b0};
            2'b11:   return {b3, b2, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (m_wrop != 2'b00) begin
            mem[m_addr[7:0]] <= m_wdata[7:0];
            if (m_wrop != 2'b01) mem[m_addr[7:0] + 8'd1] <= m_wdata[15:8];
            if (m_wrop == 2'b11) begin
                mem[m_addr[7:0] + 8'd2] <= m_wdata[23:16];
                mem[m_addr[7:0] + 8'd3] <= m_wdata[31:24];
            end
        end
        if (m_rdop != 2'b00) rd_pipe <= mem_read(m_addr[7:0], m_rdop, m_rdsign);
    end
    assign m_rdata = rd_pipe;

    int         wr_pulses = 0;
    int         cpu_acks = 0;
    logic [1:0] last_wrop = '0;
    always @(negedge clk) begin
        if (m_wrop != 2'b00) begin
            wr_pulses <= wr_pulses + 1;
            last_wrop <= m_wrop;
        end
        if (cpu_ack) cpu_acks <= cpu_acks + 1;
    end

    task automatic cpu_xfer(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] rop,
                            input logic [1:0] wop, input logic sgn,
                            output int lat, output logic [31:0] data);
        int t0;
        @(posedge clk); #1;
        cpu_addr = a; cpu_wdata = wd; cpu_rdop = rop; cpu_wrop = wop; cpu_rdsign = sgn;
        cpu_req = 1'b1;
        t0 = cyc; lat = -1; data = 32'hxxxx_xxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = cyc - t0; data = cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic z_xfer(input logic [31:0] a, input logic [1:0] rop, input logic [1:0] wop,
                          output int lat, output logic [31:0] data);
        int t0;
        @(posedge clk); #1;
        z_cpu_addr = a; z_cpu_rdop = rop; z_cpu_wrop = wop; z_cpu_req = 1'b1;
        t0 = cyc; lat = -1; data = 32'hxxxx_xxxx;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (z_cpu_ack) begin
                lat = cyc - t0; data = z_cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        z_cpu_req = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if ({busy, cpu_ack, ext_ack, gnt_id, m_rdop, m_wrop, m_rdsign} !== 9'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0",
                     {busy, cpu_ack, ext_ack, gnt_id, m_rdop, m_wrop, m_rdsign});
        end
        checks++;
        if ({m_addr, m_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_maddr: got %h expected 0", {m_addr, m_wdata});
        end
        checks++;
        if ({cpu_rdata, ext_rdata} !== 64'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 0", {cpu_rdata, ext_rdata});
        end
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_cpu_write_read;
        int lat, w0;
        logic [31:0] d;
        w0 = wr_pulses;
        cpu_xfer(32'h10, 32'hDEAD_BEEF, 2'b00, 2'b11, 1'b0, lat, d);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL wr_lat: got %0d expected 2", lat); end
        checks++;
        if (wr_pulses - w0 !== 1 || last_wrop !== 2'b11) begin
            errors++;
            $display("FAIL wr_pulse: got %0d cycles wrop %b expected 1 cycles wrop 11",
                     wr_pulses - w0, last_wrop);
        end
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", d); end
        cpu_xfer(32'h10, 32'h0, 2'b11, 2'b00, 1'b0, lat, d);
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL rd_lat: got %0d expected 3", lat); end
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL rd_data: got %h expected deadbeef", d);
        end
        // read+write together: write wins, no read strobe
        w0 = wr_pulses;
        cpu_xfer(32'h14, 32'h0000_1234, 2'b11, 2'b11, 1'b0, lat, d);
        checks++;
        if (lat !== 2 || d !== 32'h0 || wr_pulses - w0 !== 1) begin
            errors++;
            $display("FAIL rdwr_combo: got lat %0d data %h pulses %0d expected 2 0 1",
                     lat, d, wr_pulses - w0);
        end
    endtask

    task automatic test_subword;
        int lat;
        logic [31:0] d;
        cpu_xfer(32'h20, 32'h0000_0080, 2'b00, 2'b01, 1'b0, lat, d);
        cpu_xfer(32'h20, 32'h0, 2'b01, 2'b00, 1'b1, lat, d);
        checks++;
        if (d !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL byte_signed: got %h expected ffffff80", d);
        end
        cpu_xfer(32'h20, 32'h0, 2'b01, 2'b00, 1'b0, lat, d);
        checks++;
        if (d !== 32'h0000_0080) begin
            errors++; $display("FAIL byte_unsigned: got %h expected 00000080", d);
        end
    endtask

    task automatic test_simultaneous;
        int lat, t0, t_cpu, t_ext;
        logic [31:0] d, d_cpu, d_ext;
        logic g_cpu, g_ext;
        cpu_xfer(32'h30, 32'h1111_2222, 2'b00, 2'b11, 1'b0, lat, d);
        cpu_xfer(32'h34, 32'h3333_4444, 2'b00, 2'b11, 1'b0, lat, d);
        @(posedge clk); #1;
        cpu_addr = 32'h30; cpu_rdop = 2'b11; cpu_wrop = 2'b00; cpu_rdsign = 1'b0;
        ext_addr = 32'h34; ext_rdop = 2'b11; ext_wrop = 2'b00; ext_rdsign = 1'b0;
        cpu_req = 1'b1; ext_req = 1'b1;
        t0 = cyc; t_cpu = -1; t_ext = -1;
        d_cpu = '0; d_ext = '0; g_cpu = 1'bx; g_ext = 1'bx;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (cpu_ack) begin t_cpu = cyc; d_cpu = cpu_rdata; g_cpu = gnt_id; end
            if (ext_ack) begin t_ext = cyc; d_ext = ext_rdata; g_ext = gnt_id; end
            @(posedge clk); #1;
            if (t_cpu >= 0) cpu_req = 1'b0;
            if (t_ext >= 0) ext_req = 1'b0;
            if (t_cpu >= 0 && t_ext >= 0) break;
        end
        cpu_req = 1'b0; ext_req = 1'b0;
        checks++;
        if (t_cpu - t0 !== 3) begin
            errors++; $display("FAIL sim_cpu_lat: got %0d expected 3", t_cpu - t0);
        end
        checks++;
        if (t_ext - t_cpu !== 4 || t_ext < 0) begin
            errors++; $display("FAIL sim_ext_gap: got %0d expected 4", t_ext - t_cpu);
        end
        checks++;
        if ({g_cpu, g_ext} !== 2'b01) begin
            errors++; $display("FAIL sim_gnt_seq: got %b expected 01", {g_cpu, g_ext});
        end
        checks++;
        if (d_cpu !== 32'h1111_2222 || d_ext !== 32'h3333_4444) begin
            errors++;
            $display("FAIL sim_data: got %h %h expected 11112222 33334444", d_cpu, d_ext);
        end
        checks++;
        if (cpu_rdata !== 32'h1111_2222) begin
            errors++; $display("FAIL sim_cpu_hold: got %h expected 11112222", cpu_rdata);
        end
    endtask

    task automatic test_starvation;
        int n;
        logic [9:0]  seq;
        logic [31:0] d_ext;
        @(posedge clk); #1;
        cpu_addr = 32'h40; cpu_wdata = 32'h1; cpu_rdop = 2'b00; cpu_wrop = 2'b11;
        ext_addr = 32'h30; ext_rdop = 2'b11; ext_wrop = 2'b00;
        cpu_req = 1'b1; ext_req = 1'b1;
        n = 0; seq = '0; d_ext = '0;
        for (int i = 0; i < 80 && n < 10; i++) begin
            @(negedge clk);
            if (cpu_ack && n < 10) begin seq[n] = 1'b0; n++; end
            if (ext_ack && n < 10) begin seq[n] = 1'b1; d_ext = ext_rdata; n++; end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0; ext_req = 1'b0;
        checks++;
        if (n !== 10) begin errors++; $display("FAIL starve_count: got %0d acks expected 10", n); end
        checks++;
        if (seq !== 10'h210) begin
            errors++; $display("FAIL starve_seq: got %b expected 1000010000", seq);
        end
        checks++;
        if (d_ext !== 32'h1111_2222) begin
            errors++; $display("FAIL starve_ext_data: got %h expected 11112222", d_ext);
        end
    endtask

    task automatic test_reset_midflight;
        int lat, a0;
        logic [31:0] d;
        @(posedge clk); #1;
        cpu_addr = 32'h44; cpu_wdata = 32'h5555_AAAA; cpu_rdop = 2'b00; cpu_wrop = 2'b11;
        cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (m_wrop !== 2'b11) begin errors++; $display("FAIL mid_wr_cmd: got %b expected 11", m_wrop); end
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        checks++;
        if ({busy, m_wrop} !== 3'b000) begin
            errors++; $display("FAIL mid_wr_clear: got %b expected 000", {busy, m_wrop});
        end
        @(posedge clk); #1;
        reset = 1'b1;
        // reset during WAIT of a read
        @(posedge clk); #1;
        cpu_addr = 32'h30; cpu_rdop = 2'b11; cpu_wrop = 2'b00; cpu_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({busy, m_rdop} !== 3'b100) begin
            errors++; $display("FAIL mid_rd_wait: got %b expected 100", {busy, m_rdop});
        end
        #1;
        a0 = cpu_acks;
        reset = 1'b0; cpu_req = 1'b0;
        #1;
        checks++;
        if ({busy, m_rdop, cpu_ack, ext_ack} !== 5'b0) begin
            errors++;
            $display("FAIL mid_rd_clear: got %b expected 00000", {busy, m_rdop, cpu_ack, ext_ack});
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (cpu_acks !== a0) begin
            errors++; $display("FAIL mid_rd_noack: got %0d acks expected 0", cpu_acks - a0);
        end
        cpu_xfer(32'h30, 32'h0, 2'b11, 2'b00, 1'b0, lat, d);
        checks++;
        if (lat !== 3 || d !== 32'h1111_2222) begin
            errors++;
            $display("FAIL post_reset_rd: got lat %0d data %h expected 3 11112222", lat, d);
        end
    endtask

    task automatic test_rd_lat0;
        int lat;
        logic [31:0] d;
        z_xfer(32'h100, 2'b11, 2'b00, lat, d);
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL lat0_rd_lat: got %0d expected 2", lat); end
        checks++;
        if (d !== 32'h5A5A_0100) begin
            errors++; $display("FAIL lat0_rd_data: got %h expected 5a5a0100", d);
        end
        z_xfer(32'h200, 2'b00, 2'b11, lat, d);
        checks++;
        if (lat !== 2 || d !== 32'h0) begin
            errors++; $display("FAIL lat0_wr: got lat %0d data %h expected 2 0", lat, d);
        end
    endtask

    initial begin
        test_reset();
        test_cpu_write_read();
        test_subword();
        test_simultaneous();
        test_starvation();
        test_reset_midflight();
        test_rd_lat0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
